// File: rtl/dram_if.sv
// Data-memory system-bus link: command channel from the initiator, response channel back.
interface dram_if;
  logic [31:0] dram_cmd_addr;
  logic [31:0] dram_cmd_wdata;
  logic        dram_cmd_we;
  logic [3:0]  dram_cmd_wem;
  logic        dram_cmd_valid;
  logic        dram_cmd_ready;
  logic [31:0] dram_rsp_rdata;
  logic        dram_rsp_error;
  logic        dram_rsp_valid;
  logic        dram_rsp_ready;

  modport master (
    output dram_cmd_addr, dram_cmd_wdata, dram_cmd_we, dram_cmd_wem, dram_cmd_valid,
    input  dram_cmd_ready,
    input  dram_rsp_rdata, dram_rsp_error, dram_rsp_valid,
    output dram_rsp_ready
  );

  modport slave (
    input  dram_cmd_addr, dram_cmd_wdata, dram_cmd_we, dram_cmd_wem, dram_cmd_valid,
    output dram_cmd_ready,
    output dram_rsp_rdata, dram_rsp_error, dram_rsp_valid,
    input  dram_rsp_ready
  );
endinterface

// File: rtl/dram.sv
// Data-memory responder: word SRAM with byte-masked writes, in-order responses,
// a one-entry output stage plus a skid FIFO so RSP_DEPTH responses can be outstanding.
module dram #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned RSP_DEPTH = 2
) (
  input logic   clk,
  input logic   rst_n,
  dram_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned FN   = (RSP_DEPTH > 1) ? RSP_DEPTH - 1 : 1;
  localparam int unsigned PW   = (FN > 1) ? $clog2(FN) : 1;
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [32:0]   r_fifo [FN];
  logic [PW-1:0] r_rp;
  logic [PW-1:0] r_wp;
  logic [CW-1:0] r_fifo_cnt;
  logic [CW-1:0] r_out_cnt;
  logic          r_rsp_valid;
  logic          r_rsp_error;
  logic [31:0]   r_rsp_rdata;

  logic [31:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_acc;
  logic          w_done;
  logic          w_out_free;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  logic [32:0]   w_new;

  // Wrap a skid-FIFO pointer modulo the FIFO depth.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FN - 1)) ? '0 : p + PW'(1);
  endfunction

  // Address decode: addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign w_off      = bus.dram_cmd_addr - BASE_ADDR;
  assign w_in_range = (w_off < SPAN);
  assign w_idx      = w_off[AW+1:2];

  assign w_acc        = bus.dram_cmd_valid & bus.dram_cmd_ready;
  assign w_done       = r_rsp_valid & bus.dram_rsp_ready;
  assign w_out_free   = ~r_rsp_valid | w_done;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = w_out_free & ~w_fifo_empty;
  assign w_push       = w_acc & ~(w_out_free & w_fifo_empty);

  // Response payload {error, rdata}: only in-range reads return memory contents.
  assign w_new = {~w_in_range, (w_in_range & ~bus.dram_cmd_we) ? r_mem[w_idx] : 32'h0};

  assign bus.dram_cmd_ready = (r_out_cnt < CW'(RSP_DEPTH));
  assign bus.dram_rsp_valid = r_rsp_valid;
  assign bus.dram_rsp_error = r_rsp_error;
  assign bus.dram_rsp_rdata = r_rsp_rdata;

  // SRAM byte-masked write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_acc && bus.dram_cmd_we && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dram_cmd_wem[i]) r_mem[w_idx][8*i +: 8] <= bus.dram_cmd_wdata[8*i +: 8];
      end
    end
  end

  // Skid FIFO storage for responses that arrive while the output stage is stalled.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_new;
  end

  // Outstanding count, output stage and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt   <= '0;
      r_fifo_cnt  <= '0;
      r_rp        <= '0;
      r_wp        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      if (w_acc && !w_done)      r_out_cnt <= r_out_cnt + CW'(1);
      else if (!w_acc && w_done) r_out_cnt <= r_out_cnt - CW'(1);

      if (w_pop) begin
        r_rsp_valid                <= 1'b1;
        {r_rsp_error, r_rsp_rdata} <= r_fifo[r_rp];
        r_rp                       <= ptr_inc(r_rp);
      end else if (w_out_free && w_acc) begin
        r_rsp_valid                <= 1'b1;
        {r_rsp_error, r_rsp_rdata} <= w_new;
      end else if (w_done) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_push) r_wp <= ptr_inc(r_wp);

      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CW'(1);
      else if (w_pop && !w_push) r_fifo_cnt <= r_fifo_cnt - CW'(1);
    end
  end

endmodule
